// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state encoding, default widths and opcode bit positions for alu_arb.
package alu_arb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 12;
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker; ptr=1 favours input 1 when both are valid.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] && (!valid[1] || !ptr);
    assign grant[1] = valid[1] && (!valid[0] || ptr);
endmodule

// File: rtl/alu_arb.sv
// alu_arb: arbitrates two requesters onto one shared combinational ALU, one transaction at a time.
// ALU_ARB_OPCHK_EN: reject non-one-hot opcodes with result 0 and err=1 instead of issuing them.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_err,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result
);
    state_t state, state_nx;
    logic ptr, owner_q, err_q, hs, op_bad, rsp_ack;
    logic [1:0] grant;
    logic [OP_W-1:0] op_q;
    logic [DATA_W-1:0] src1_q, src2_q, result_q;

    rr_arb2 u_rr (.valid({req1_valid, req0_valid}), .ptr(ptr), .grant(grant));

`ifdef ALU_ARB_OPCHK_EN
    assign op_bad = (op_q == '0) || ((op_q & (op_q - OP_W'(1))) != '0);
`else
    assign op_bad = 1'b0;
`endif

    assign hs      = (state == IDLE) && (grant != 2'b00);
    assign rsp_ack = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_nx    = (state == IDLE) ? (hs ? EXEC : IDLE) :
                      (state == EXEC) ? RESP : (rsp_ack ? IDLE : RESP);
        req0_ready  = (state == IDLE) && grant[0];
        req1_ready  = (state == IDLE) && grant[1];
        rsp0_valid  = (state == RESP) && !owner_q;
        rsp1_valid  = (state == RESP) && owner_q;
        rsp0_result = rsp0_valid ? result_q : '0;
        rsp1_result = rsp1_valid ? result_q : '0;
        rsp0_err    = rsp0_valid && err_q;
        rsp1_err    = rsp1_valid && err_q;
        alu_op      = (state == EXEC && !op_bad) ? op_q : '0;
        alu_src1    = (state == EXEC && !op_bad) ? src1_q : '0;
        alu_src2    = (state == EXEC && !op_bad) ? src2_q : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner_q  <= 1'b0;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs) begin
                owner_q <= grant[1];
                ptr     <= !grant[1];
                op_q    <= grant[1] ? req1_op : req0_op;
                src1_q  <= grant[1] ? req1_src1 : req0_src1;
                src2_q  <= grant[1] ? req1_src2 : req0_src2;
            end
            // Rejected opcodes never reach the ALU, so their result is forced to 0.
            if (state == EXEC) begin
                result_q <= op_bad ? '0 : alu_result;
                err_q    <= op_bad;
            end
        end
    end
endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter DATA_W, 32, operand/result width.
REQ-002 Parameter OP_W, 12, one-hot ALU opcode width, bit order add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui (bit 0..11).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  out  1  arbiter accepts requester N this cycle.
REQ-007 reqN_op  in  OP_W  one-hot opcode; reqN_src1, reqN_src2  in  DATA_W  operands.
REQ-008 rspN_valid  out  1  result for requester N held; rspN_ready  in  1  requester N consumes it.
REQ-009 rspN_result  out  DATA_W  result; rspN_err  out  1  opcode-error flag.
REQ-010 alu_op  out  OP_W, alu_src1, alu_src2  out  DATA_W  drive shared combinational ALU; alu_result  in  DATA_W  its output.

Function
REQ-011 FSM states IDLE, EXEC, RESP; exactly one transaction outstanding.
REQ-012 IDLE: reqN_ready=1 only for the granted requester; handshake = valid&&ready; on handshake latch op/src1/src2/owner, go EXEC.
REQ-013 Grant: one valid -> that one; both valid -> the requester not served last (round-robin pointer); pointer updates only on handshake.
REQ-014 EXEC: alu_op/src1/src2 driven from latched registers; alu_result captured into result register at end of cycle; go RESP.
REQ-015 Outside EXEC alu_op=0, alu_src1=0, alu_src2=0.
REQ-016 RESP: rsp<owner>_valid=1 with stable result/err until rsp<owner>_ready=1; then IDLE; other rsp_valid stays 0.
REQ-017 All reqN_ready=0 in EXEC and RESP; no new acceptance in the RESP-exit cycle.
REQ-018 Latency: handshake at cycle T -> rsp_valid from cycle T+2; minimum issue interval 3 cycles.
REQ-019 rspN_ready while rspN_valid=0 is ignored; reqN_op content is not checked unless REQ-024 applies.
REQ-020 Result is the ALU's 32-bit value unmodified; no width extension or truncation.

Reset
REQ-021 resetn=0 asynchronously forces IDLE, round-robin pointer to favour req0, latched op/operands/result/err/owner to 0.
REQ-022 During and after reset until first handshake: all reqN_ready per REQ-013, rspN_valid=0, rspN_result=0, rspN_err=0, alu_* =0.
REQ-023 Reset in EXEC or RESP aborts the transaction; no response is ever delivered for it.

Configuration
REQ-024 Macro ALU_ARB_OPCHK_EN defined: a request whose op is not exactly one-hot is accepted, not issued (alu_* stay 0 in EXEC), responds with result 0 and rspN_err=1; same latency.
REQ-025 Macro undefined: no check, op passed as latched, rspN_err tied 0.

Structure
REQ-026 Package alu_arb_pkg holds the state enum, OP_W, DATA_W defaults and named opcode bit-index constants.
REQ-027 Sub-module rr_arb2: two-input round-robin picker (inputs valids, pointer; outputs one-hot grant); all FSM and datapath regs stay in alu_arb.

Verification
REQ-028 Reset release, req0 add src1=5 src2=7 -> req0_ready at cycle 0, alu_op=0x001 in cycle 1, rsp0_valid cycle 2 with result 12, err 0.
REQ-029 Both valid every cycle, req0 sub 3-5, req1 sltu 3,5 -> grants alternate 0,1,0; rsp0 0xFFFFFFFE, rsp1 0x00000001.
REQ-030 rsp1_ready held 0 for 10 cycles after rsp1_valid -> result stable, all req_ready 0, no second issue until release.
REQ-031 resetn pulsed low during EXEC of req0 -> rsp0_valid never asserts, next grant goes to req0.
REQ-032 ALU_ARB_OPCHK_EN defined, req1 op=0x003 -> alu_op stays 0, rsp1_result 0, rsp1_err 1; undefined -> alu_op=0x003, err 0.
